// File: rtl/cart_pkg.sv
// Shared address map, register encodings and sizing helpers for the cartridge controller.
package cart_pkg;

    localparam logic [15:0] ROM0_LO      = 16'h0000;
    localparam logic [15:0] ROM0_HI      = 16'h3FFF;
    localparam logic [15:0] ROMX_LO      = 16'h4000;
    localparam logic [15:0] ROMX_HI      = 16'h7FFF;
    localparam logic [15:0] REG_RAMEN_HI = 16'h1FFF;
    localparam logic [15:0] REG_BANK1_HI = 16'h3FFF;
    localparam logic [15:0] REG_BANK2_HI = 16'h5FFF;
    localparam logic [15:0] REG_MODE_HI  = 16'h7FFF;
    localparam logic [15:0] RAM_LO       = 16'hA000;
    localparam logic [15:0] RAM_HI       = 16'hBFFF;
    localparam logic [15:0] BOOT_HI      = 16'h00FF;
    localparam logic [15:0] BOOT_SWITCH  = 16'hFF50;

    localparam logic [3:0] RAM_ENABLE_KEY = 4'hA;

    typedef enum logic {
        MODE_SIMPLE   = 1'b0,
        MODE_ADVANCED = 1'b1
    } mbc_mode_e;

    function automatic int unsigned ROM_BANK_W(input int unsigned rom_banks);
        return $clog2(rom_banks);
    endfunction

    // Kept at least 1 bit wide so single-bank and RAM-less builds still have a legal port.
    function automatic int unsigned RAM_BANK_W(input int unsigned ram_banks);
        return (ram_banks == 4) ? 2 : 1;
    endfunction

    function automatic logic [7:0] boot_dmg(input logic [7:0] idx);
        case (idx)
            8'h00:   return 8'h31;
            8'h01:   return 8'hFE;
            8'h02:   return 8'hFF;
            8'h03:   return 8'hAF;
            default: return idx ^ 8'hA5;
        endcase
    endfunction

endpackage

// File: rtl/bus_if.sv
// System bus bundle as seen by a memory-mapped peripheral.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        read_en;
    logic        write_en;

    modport Peripheral_side (input addr, wdata, read_en, write_en, output rdata);
    modport Host_side       (output addr, wdata, read_en, write_en, input rdata);
endinterface

// File: rtl/mbc1_regs.sv
// MBC1 mapper registers and boot switch; produces masked ROM/RAM bank numbers.
module mbc1_regs
    import cart_pkg::*;
#(
    parameter int unsigned ROM_BANKS = 64,
    parameter int unsigned RAM_BANKS = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [15:0]                         addr,
    input  logic [7:0]                          wdata,
    input  logic                                write_en,
    output logic                                ram_en,
    output logic                                boot_off,
    output logic [ROM_BANK_W(ROM_BANKS)-1:0]    rom_bank0,
    output logic [ROM_BANK_W(ROM_BANKS)-1:0]    rom_bankx,
    output logic [RAM_BANK_W(RAM_BANKS)-1:0]    ram_bank
);

    localparam int unsigned RBW = ROM_BANK_W(ROM_BANKS);

    logic [4:0] bank1;
    logic [1:0] bank2;
    mbc_mode_e  mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en   <= 1'b0;
            bank1    <= '0;
            bank2    <= '0;
            mode     <= MODE_SIMPLE;
            boot_off <= 1'b0;
        end else if (write_en) begin
            if (addr <= REG_RAMEN_HI)
                ram_en <= (wdata[3:0] == RAM_ENABLE_KEY);
            else if (addr <= REG_BANK1_HI)
                bank1 <= (wdata[4:0] == 5'd0) ? 5'd1 : wdata[4:0];
            else if (addr <= REG_BANK2_HI)
                bank2 <= wdata[1:0];
            else if (addr <= REG_MODE_HI)
                mode <= mbc_mode_e'(wdata[0]);
            else if (addr == BOOT_SWITCH && wdata != 8'h00)
                boot_off <= 1'b1;
        end
    end

    // Power-of-two bank count: masking with ROM_BANKS-1 is keeping the low RBW bits.
    logic [6:0] bank0_full;
    logic [6:0] bankx_full;

    assign bank0_full = (mode == MODE_ADVANCED) ? {bank2, 5'b0} : '0;
    assign bankx_full = {bank2, bank1};
    assign rom_bank0  = bank0_full[RBW-1:0];
    assign rom_bankx  = bankx_full[RBW-1:0];

    if (RAM_BANKS == 4) begin : g_ram_bank4
        assign ram_bank = (mode == MODE_ADVANCED) ? bank2 : '0;
    end else begin : g_ram_bank1
        assign ram_bank = '0;
    end

endmodule

// File: rtl/cartridge_mbc.sv
// MBC1-style cartridge: ROM/RAM arrays, side-band ROM loader and bus read mux.
module cartridge_mbc
    import cart_pkg::*;
#(
    parameter int unsigned ROM_BANKS = 64,
    parameter int unsigned RAM_BANKS = 4,
    parameter bit          BOOT_EN   = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    Bus_if.Peripheral_side                         bus,
    input  logic                                   load_en,
    input  logic [14+ROM_BANK_W(ROM_BANKS)-1:0]    load_addr,
    input  logic [7:0]                             load_data
);

    localparam int unsigned RBW       = ROM_BANK_W(ROM_BANKS);
    localparam int unsigned RAW       = RAM_BANK_W(RAM_BANKS);
    localparam int unsigned ROM_DEPTH = ROM_BANKS * 16384;
    localparam int unsigned ROM_AW    = 14 + RBW;

    logic           ram_en;
    logic           boot_off;
    logic [RBW-1:0] rom_bank0;
    logic [RBW-1:0] rom_bankx;
    logic [RAW-1:0] ram_bank;

    mbc1_regs #(
        .ROM_BANKS (ROM_BANKS),
        .RAM_BANKS (RAM_BANKS)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .addr      (bus.addr),
        .wdata     (bus.wdata),
        .write_en  (bus.write_en),
        .ram_en    (ram_en),
        .boot_off  (boot_off),
        .rom_bank0 (rom_bank0),
        .rom_bankx (rom_bankx),
        .ram_bank  (ram_bank)
    );

    logic [7:0] rom [ROM_DEPTH];

    always_ff @(posedge clk) begin
        if (load_en)
            rom[load_addr] <= load_data;
    end

    logic        ram_sel;
    logic        ram_on;
    logic [7:0]  ram_q;

    assign ram_sel = (bus.addr >= RAM_LO) && (bus.addr <= RAM_HI);

    if (RAM_BANKS > 0) begin : g_ram
        localparam int unsigned RAM_DEPTH = (RAM_BANKS == 4) ? 4 * 8192 : 8192;
        localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);

        logic [7:0]        ram [RAM_DEPTH];
        logic [RAM_AW-1:0] ram_idx;

        if (RAM_BANKS == 4) begin : g_idx4
            assign ram_idx = {ram_bank, bus.addr[12:0]};
        end else begin : g_idx1
            assign ram_idx = bus.addr[12:0];
        end

        assign ram_on = ram_en;
        assign ram_q  = ram[ram_idx];

        always_ff @(posedge clk) begin
            if (bus.write_en && ram_sel && ram_on)
                ram[ram_idx] <= bus.wdata;
        end
    end else begin : g_no_ram
        assign ram_on = 1'b0;
        assign ram_q  = 8'hFF;
    end

    always_comb begin
        bus.rdata = 8'hFF;
        if (bus.read_en) begin
            if (BOOT_EN && !boot_off && bus.addr <= BOOT_HI)
                bus.rdata = boot_dmg(bus.addr[7:0]);
            else if (bus.addr <= ROM0_HI)
                bus.rdata = rom[ROM_AW'({rom_bank0, bus.addr[13:0]})];
            else if (bus.addr <= ROMX_HI)
                bus.rdata = rom[ROM_AW'({rom_bankx, bus.addr[13:0]})];
            else if (ram_sel)
                bus.rdata = ram_on ? ram_q : 8'hFF;
            else if (bus.addr == BOOT_SWITCH)
                bus.rdata = {7'h7F, boot_off};
        end
    end

endmodule

// File: tb/tb_cartridge_mbc.sv
// Scoreboard bench: a 128-bank/4-RAM-bank build and an 8-bank/RAM-less build share one bus stream.
module tb_cartridge_mbc;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic        ld_b;
    logic [20:0] load_addr;
    logic [7:0]  load_data;

    always #5 clk = ~clk;

    Bus_if b0 ();
    Bus_if b1 ();

    assign b1.addr     = b0.addr;
    assign b1.wdata    = b0.wdata;
    assign b1.write_en = b0.write_en;
    assign b1.read_en  = b0.read_en;

    cartridge_mbc #(.ROM_BANKS(128), .RAM_BANKS(4), .BOOT_EN(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (b0),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    cartridge_mbc #(.ROM_BANKS(8), .RAM_BANKS(0), .BOOT_EN(1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (b1),
        .load_en   (load_en & ld_b),
        .load_addr (load_addr[16:0]),
        .load_data (load_data)
    );

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (b0.read_en) begin
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL A unexpected read addr=%h got %h, nothing expected", b0.addr, b0.rdata);
            end else begin
                e = q_a.pop_front();
                if (b0.rdata !== e.exp) begin
                    n_fail++;
                    $display("FAIL A %s: got %h, want %h", e.name, b0.rdata, e.exp);
                end
            end
        end else begin
            n_tests++;
            if (b0.rdata !== 8'hFF) begin
                n_fail++;
                $display("FAIL A idle_rdata: got %h, want ff", b0.rdata);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b1.read_en) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL B unexpected read addr=%h got %h, nothing expected", b1.addr, b1.rdata);
            end else begin
                e = q_b.pop_front();
                if (b1.rdata !== e.exp) begin
                    n_fail++;
                    $display("FAIL B %s: got %h, want %h", e.name, b1.rdata, e.exp);
                end
            end
        end
    end

    task automatic expect_rd(input string name, input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        e.name = name; e.exp = ea; q_a.push_back(e);
        e.exp = eb;    q_b.push_back(e);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        b0.addr = a; b0.wdata = d; b0.write_en = 1'b1;
        @(posedge clk); #1;
        b0.write_en = 1'b0;
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [7:0] ea, input logic [7:0] eb);
        expect_rd(name, ea, eb);
        b0.addr = a; b0.read_en = 1'b1;
        @(posedge clk); #1;
        b0.read_en = 1'b0;
    endtask

    task automatic rd_wr(input string name, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] ea, input logic [7:0] eb);
        expect_rd(name, ea, eb);
        b0.addr = a; b0.wdata = d; b0.read_en = 1'b1; b0.write_en = 1'b1;
        @(posedge clk); #1;
        b0.read_en = 1'b0; b0.write_en = 1'b0;
    endtask

    task automatic ld(input logic [20:0] a, input logic [7:0] d, input logic to_b);
        load_addr = a; load_data = d; load_en = 1'b1; ld_b = to_b;
        @(posedge clk); #1;
        load_en = 1'b0; ld_b = 1'b0;
    endtask

    task automatic wr_ld(input logic [15:0] a, input logic [7:0] d,
                         input logic [20:0] la, input logic [7:0] ldat);
        b0.addr = a; b0.wdata = d; b0.write_en = 1'b1;
        load_addr = la; load_data = ldat; load_en = 1'b1; ld_b = 1'b1;
        @(posedge clk); #1;
        b0.write_en = 1'b0; load_en = 1'b0; ld_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        b0.addr = '0; b0.wdata = '0; b0.read_en = 1'b0; b0.write_en = 1'b0;
        load_en = 1'b0; ld_b = 1'b0; load_addr = '0; load_data = '0;
        #12 reset = 1'b0;
        @(posedge clk); #1;

        ld(21'h000100, 8'h11, 1'b1);
        ld(21'h004000, 8'h33, 1'b1);
        ld(21'h034000, 8'h44, 1'b0);
        ld(21'h100000, 8'h66, 1'b0);
        ld(21'h000000, 8'h77, 1'b1);

        rd("rst_ff50",      16'hFF50, 8'hFE, 8'hFE);
        rd("rst_ram",       16'hA000, 8'hFF, 8'hFF);
        rd("rst_boot0",     16'h0000, 8'h31, 8'h31);
        rd("rst_romx_bk0",  16'h4100, 8'h11, 8'h11);
        rd("unmapped_8000", 16'h8000, 8'hFF, 8'hFF);
        rd("unmapped_c000", 16'hC000, 8'hFF, 8'hFF);

        wr_ld(16'h2000, 8'h05, 21'h014000, 8'h22);
        rd("bank5",         16'h4000, 8'h22, 8'h22);

        wr(16'hFF50, 8'h00);
        rd("boot_kept",     16'h0000, 8'h31, 8'h31);
        rd_wr("ff50_prewr", 16'hFF50, 8'h01, 8'hFE, 8'hFE);
        rd("ff50_off",      16'hFF50, 8'hFF, 8'hFF);
        rd("rom0_0100",     16'h0100, 8'h11, 8'h11);
        rd("rom0_0000",     16'h0000, 8'h77, 8'h77);
        wr(16'hFF50, 8'h00);
        rd("ff50_sticky",   16'hFF50, 8'hFF, 8'hFF);

        wr(16'h2100, 8'h00);
        rd("bank1_zero",    16'h4000, 8'h33, 8'h33);
        wr(16'h2000, 8'h20);
        rd("bank1_0x20",    16'h4000, 8'h33, 8'h33);
        wr(16'h2000, 8'h0D);
        rd("bank_0d_mask",  16'h4000, 8'h44, 8'h22);

        wr(16'h0000, 8'h0A);
        wr(16'hA000, 8'h12);
        rd("ram_12",        16'hA000, 8'h12, 8'hFF);
        wr(16'h0000, 8'h00);
        rd("ram_disabled",  16'hA000, 8'hFF, 8'hFF);
        wr(16'hA000, 8'h55);
        wr(16'h1FFF, 8'h1A);
        rd("ram_drop_wr",   16'hA000, 8'h12, 8'hFF);
        wr(16'hA000, 8'h55);
        rd("ram_55",        16'hA000, 8'h55, 8'hFF);

        wr(16'h4000, 8'h02);
        rd("ram_mode0",     16'hA000, 8'h55, 8'hFF);
        wr(16'h6000, 8'h01);
        wr(16'hA000, 8'h99);
        rd("ram_bank2",     16'hA000, 8'h99, 8'hFF);
        rd("rom0_bank64",   16'h0000, 8'h66, 8'h77);
        wr(16'h6000, 8'h00);
        rd("ram_back0",     16'hA000, 8'h55, 8'hFF);
        rd("rom0_back0",    16'h0000, 8'h77, 8'h77);
        wr(16'h6000, 8'h01);

        expect_rd("ff50_in_reset", 8'hFE, 8'hFE);
        b0.addr = 16'hFF50; b0.read_en = 1'b1;
        #1 reset = 1'b1;
        #6 reset = 1'b0;
        @(posedge clk); #1;
        b0.read_en = 1'b0;

        rd("post_rst_ram",  16'hA000, 8'hFF, 8'hFF);
        rd("post_rst_boot", 16'h0000, 8'h31, 8'h31);
        rd("post_rst_ff50", 16'hFF50, 8'hFE, 8'hFE);
        rd("post_rst_romx", 16'h4100, 8'h11, 8'h11);
        wr(16'h0000, 8'h0A);
        rd("kept_ram0",     16'hA000, 8'h55, 8'hFF);
        wr(16'h4000, 8'h02);
        wr(16'h6000, 8'h01);
        rd("kept_ram2",     16'hA000, 8'h99, 8'hFF);
        wr(16'hFF50, 8'h01);
        rd("kept_rom64",    16'h0000, 8'h66, 8'h77);

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++)
            @(posedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: pending A=%0d B=%0d, want 0", q_a.size(), q_b.size());
        end

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
